// File: rtl/pipe_commit_tracker.sv
// Single-token pipeline tracker: launch, per-stage token chain, commit and sticky end/timeout/error flags.
// Optional macro PIPE_TRACK_GATE_EN gates token entry into stage 1 with s1_fire_i.
module pipe_commit_tracker #(
    parameter int STAGES     = 4,
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 50,
    parameter int CNT_SAT    = 132
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic              s1_fire_i,
    input  logic [STAGES-1:0] stall_i,
    input  logic              flush_i,
    output logic              start_o,
    output logic              started_o,
    output logic [STAGES-1:0] tok_o,
    output logic              commit_o,
    output logic              ended_o,
    output logic              ended2_o,
    output logic              timeout_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(CNT_SAT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v < SAT_C) ? v + CNT_W'(1) : v;
    endfunction

    logic              start_q;
    logic              started_q;
    logic              commit_q;
    logic              ended_q;
    logic              ended2_q;
    logic              timeout_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STAGES-1:1] tok_q;
    logic [STAGES-1:0] tok;
    logic [STAGES-1:0] adv;
    logic              lost;

    // Stage 1 has no register: the token lives there only during the start_o cycle.
`ifdef PIPE_TRACK_GATE_EN
    assign tok[0] = start_q & s1_fire_i;
`else
    logic unused_fire;
    assign unused_fire = s1_fire_i;
    assign tok[0]      = start_q;
`endif

    assign tok[STAGES-1:1] = tok_q;
    assign adv             = tok & ~stall_i;

    // A token leaving stage k-1 into a stalled stage k is dropped.
    always_comb begin
        lost = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1] && stall_i[k]) lost = 1'b1;
        end
        lost = lost & ~flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            start_q   <= issue_i & ~start_q & ~started_q;
            started_q <= started_q | start_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q    <= '0;
            commit_q <= 1'b0;
        end else if (flush_i) begin
            tok_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                if (!stall_i[k]) tok_q[k] <= adv[k-1];
            end
            commit_q <= adv[STAGES-1];
        end
    end

    // Sticky flags evaluate on pre-edge counter and commit values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ended_q   <= 1'b0;
            ended2_q  <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (start_q || started_q) cnt_q <= sat_inc(cnt_q);
            if (commit_q && started_q && !ended_q && (cnt_q <= MAX_C)) ended_q <= 1'b1;
            if (commit_q && started_q && ended_q && !ended2_q) ended2_q <= 1'b1;
            if ((cnt_q > MAX_C) && !ended_q) timeout_q <= 1'b1;
            if (lost) err_q <= 1'b1;
        end
    end

    assign start_o     = start_q;
    assign started_o   = started_q;
    assign tok_o       = tok;
    assign commit_o    = commit_q;
    assign ended_o     = ended_q;
    assign ended2_o    = ended2_q;
    assign timeout_o   = timeout_q;
    assign err_o       = err_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_commit_tracker.sv
// Bench for pipe_commit_tracker: directed scenarios plus random stimulus against a token-position model.
module tb_pipe_commit_tracker;

    localparam int S    = 4;
    localparam int MAXC = 50;
    localparam int SAT  = 132;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_i;
    logic       s1_fire_i;
    logic [3:0] stall_i;
    logic       flush_i;
    logic       start_o, started_o, commit_o, ended_o, ended2_o, timeout_o, err_o;
    logic [3:0] tok_o;
    logic [7:0] cycle_cnt_o;
    logic [18:0] obs;

    always #5 clk = ~clk;

    pipe_commit_tracker #(.STAGES(4), .CNT_W(8), .MAX_CYCLES(50), .CNT_SAT(132)) dut (
        .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .s1_fire_i(s1_fire_i),
        .stall_i(stall_i), .flush_i(flush_i), .start_o(start_o), .started_o(started_o),
        .tok_o(tok_o), .commit_o(commit_o), .ended_o(ended_o), .ended2_o(ended2_o),
        .timeout_o(timeout_o), .err_o(err_o), .cycle_cnt_o(cycle_cnt_o)
    );

    assign obs = {start_o, started_o, tok_o, commit_o, ended_o, ended2_o, timeout_o, err_o, cycle_cnt_o};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the token is tracked as a stage number, not as a register chain.
    bit m_start, m_started, m_commit, m_ended, m_ended2, m_timeout, m_err, m_fire;
    int m_pos;
    int m_cnt;

    function automatic bit gate(input bit f);
`ifdef PIPE_TRACK_GATE_EN
        return f;
`else
        return f | 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_start = 0; m_started = 0; m_commit = 0; m_ended = 0; m_ended2 = 0;
        m_timeout = 0; m_err = 0; m_fire = 0; m_pos = 0; m_cnt = 0;
    endfunction

    function automatic logic [18:0] model_vec();
        logic [3:0] t;
        t = '0;
        if (m_start && gate(m_fire)) t[0] = 1'b1;
        if (m_pos >= 2) t[m_pos-1] = 1'b1;
        return {m_start, m_started, t, m_commit, m_ended, m_ended2, m_timeout, m_err, 8'(m_cnt)};
    endfunction

    function automatic void model_step(input bit iss, input bit fire, input logic [3:0] st, input bit fl);
        int  cur, npos, ncnt;
        bit  advance, ncommit, nended, nended2, ntimeout, nerr, nstart, nstarted;
        cur     = (m_start && gate(fire)) ? 1 : m_pos;
        advance = (cur != 0) && !st[cur-1];
        nerr    = m_err | (!fl && advance && (cur < S) && st[cur]);
        npos    = 0;
        ncommit = 0;
        if (!fl && cur != 0) begin
            if (advance) begin
                if (cur == S) ncommit = 1;
                else if (!st[cur]) npos = cur + 1;
            end else if (cur > 1) begin
                npos = cur;
            end
        end
        ncnt     = ((m_start || m_started) && m_cnt < SAT) ? m_cnt + 1 : m_cnt;
        nended   = m_ended | (m_commit && m_started && !m_ended && m_cnt <= MAXC);
        nended2  = m_ended2 | (m_commit && m_started && m_ended && !m_ended2);
        ntimeout = m_timeout | (m_cnt > MAXC && !m_ended);
        nstart   = iss && !m_start && !m_started;
        nstarted = m_started | m_start;
        m_pos = npos; m_commit = ncommit; m_err = nerr; m_cnt = ncnt; m_ended = nended;
        m_ended2 = nended2; m_timeout = ntimeout; m_start = nstart; m_started = nstarted;
    endfunction

    task automatic cyc(input bit iss, input bit fire, input logic [3:0] st, input bit fl);
        issue_i = iss; s1_fire_i = fire; stall_i = st; flush_i = fl;
        @(posedge clk);
        model_step(iss, fire, st, fl);
        m_fire = fire;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; issue_i = 1'b0; s1_fire_i = 1'b0; stall_i = '0; flush_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs !== 19'd0) begin n_bad++; $display("FAIL reset_init: got %h want %h", obs, 19'd0); end
        cyc(1, 1, 4'b0, 0); cyc(0, 1, 4'b0, 0); cyc(0, 1, 4'b0, 0);
        n_vec++;
        if (obs !== model_vec()) begin n_bad++; $display("FAIL reset_pre: got %h want %h", obs, model_vec()); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs !== 19'd0) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, 19'd0); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 4'b0, 0);
            n_vec++;
            if (obs !== model_vec() || started_o !== 1'b0) begin
                n_bad++; $display("FAIL reset_relaunch: got %h want %h", obs, model_vec());
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1, 1, 4'b0, 0);
        for (int c = 1; c <= 10; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL basic c%0d: got %h want %h", c, obs, model_vec()); end
            if (c == 5) begin
                n_vec++;
                if (commit_o !== 1'b1 || cycle_cnt_o !== 8'd4) begin
                    n_bad++; $display("FAIL basic_commit: got commit=%b cnt=%0d want commit=1 cnt=4", commit_o, cycle_cnt_o);
                end
            end
            if (c >= 6) begin
                n_vec++;
                if (ended_o !== 1'b1) begin n_bad++; $display("FAIL basic_ended c%0d: got %b want 1", c, ended_o); end
            end
            cyc(0, 1, 4'b0, 0);
        end
    endtask

    task automatic test_stall3();
        do_reset();
        cyc(1, 1, 4'b0, 0);
        for (int c = 1; c <= 12; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL stall3 c%0d: got %h want %h", c, obs, model_vec()); end
            if (c == 8) begin
                n_vec++;
                if (commit_o !== 1'b1 || err_o !== 1'b0) begin
                    n_bad++; $display("FAIL stall3_commit: got commit=%b err=%b want commit=1 err=0", commit_o, err_o);
                end
            end
            cyc(0, 1, (c >= 3 && c <= 5) ? 4'b0111 : 4'b0000, 0);
        end
    endtask

    task automatic test_err();
        do_reset();
        cyc(1, 1, 4'b0, 0);
        for (int c = 1; c <= 10; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL err c%0d: got %h want %h", c, obs, model_vec()); end
            if (c == 2) begin
                n_vec++;
                if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", err_o); end
            end
            cyc(0, 1, (c == 1) ? 4'b0010 : 4'b0000, 0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(1, 1, 4'b0, 0);
        for (int c = 1; c <= 140; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL timeout c%0d: got %h want %h", c, obs, model_vec()); end
            if (c == 52 || c == 53) begin
                n_vec++;
                if (timeout_o !== (c == 53)) begin
                    n_bad++; $display("FAIL timeout_edge c%0d: got %b want %b", c, timeout_o, c == 53);
                end
            end
            if (c == 65) begin
                n_vec++;
                if (commit_o !== 1'b1) begin n_bad++; $display("FAIL timeout_commit: got %b want 1", commit_o); end
            end
            cyc(0, 1, (c >= 4 && c <= 63) ? 4'b1000 : 4'b0000, 0);
        end
        n_vec++;
        if (ended_o !== 1'b0 || timeout_o !== 1'b1 || cycle_cnt_o !== 8'd132) begin
            n_bad++; $display("FAIL timeout_final: got ended=%b to=%b cnt=%0d want 0 1 132", ended_o, timeout_o, cycle_cnt_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cyc(1, 1, 4'b0, 0);
        for (int c = 1; c <= 10; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL flush c%0d: got %h want %h", c, obs, model_vec()); end
            if (c >= 4) begin
                n_vec++;
                if (tok_o !== 4'b0 || commit_o !== 1'b0) begin
                    n_bad++; $display("FAIL flush_tok c%0d: got tok=%b commit=%b want 0 0", c, tok_o, commit_o);
                end
            end
            if (c == 7) begin
                n_vec++;
                if (start_o !== 1'b0 || started_o !== 1'b1) begin
                    n_bad++; $display("FAIL flush_reissue: got start=%b started=%b want 0 1", start_o, started_o);
                end
            end
            cyc(c == 6, 1, 4'b0, c == 3);
        end
    endtask

    task automatic test_ended2();
        do_reset();
        cyc(1, 1, 4'b0, 0);
        repeat (7) cyc(0, 1, 4'b0, 0);
        n_vec++;
        if (obs !== model_vec()) begin n_bad++; $display("FAIL ended2_pre: got %h want %h", obs, model_vec()); end
        force dut.commit_q = 1'b1;
        m_commit = 1'b1;
        #1;
        n_vec++;
        if (obs !== model_vec()) begin n_bad++; $display("FAIL ended2_force: got %h want %h", obs, model_vec()); end
        @(negedge clk);
        release dut.commit_q;
        @(posedge clk);
        model_step(0, 1, 4'b0, 0);
        #1;
        n_vec++;
        if (ended2_o !== 1'b1) begin n_bad++; $display("FAIL ended2_set: got %b want 1", ended2_o); end
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL ended2 c%0d: got %h want %h", c, obs, model_vec()); end
            cyc(0, 1, 4'b0, 0);
        end
    endtask

`ifdef PIPE_TRACK_GATE_EN
    task automatic test_gate();
        do_reset();
        cyc(1, 0, 4'b0, 0);
        for (int c = 1; c <= 10; c++) begin
            n_vec++;
            if (obs !== model_vec()) begin n_bad++; $display("FAIL gate c%0d: got %h want %h", c, obs, model_vec()); end
            if (c == 3 || c == 5) begin
                n_vec++;
                if (tok_o !== 4'b0 || commit_o !== 1'b0) begin
                    n_bad++; $display("FAIL gate_block c%0d: got tok=%b commit=%b want 0 0", c, tok_o, commit_o);
                end
            end
            cyc(0, c > 1, 4'b0, 0);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] st;
        for (int t = 0; t < 24; t++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                for (int b = 0; b < 4; b++) st[b] = ($urandom_range(5) == 0);
                cyc($urandom_range(3) == 0, $urandom_range(3) != 0, st, $urandom_range(19) == 0);
                n_vec++;
                if (obs !== model_vec()) begin
                    n_bad++; $display("FAIL random t%0d c%0d: got %h want %h", t, c, obs, model_vec());
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; issue_i = 1'b0; s1_fire_i = 1'b0; stall_i = '0; flush_i = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_stall3();
        test_err();
        test_timeout();
        test_flush();
        test_ended2();
`ifdef PIPE_TRACK_GATE_EN
        test_gate();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
